alu_issue_ctrl: RTL

Decode-and-issue stage feeding the 8-bit ALU in the pipelined CPU. It accepts 16-bit instructions through a valid/ready handshake and registers the decoded ALU function code, operand selects and memory/writeback controls. It holds one instruction in execute while the ALU evaluates it, then captures the ALU's `z`/`carry` flags and resolves branches, flushing younger instructions when a branch is taken. It also inserts load-use bubbles.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_decode.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode/function codes, instruction
// field positions and the decoded-control bundle handed from decode to issue.
package cpu_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_LO = 0;

    // ALU function codes equal the opcode of the instruction that issues them.
    localparam logic [3:0] FN_NOP   = 4'h0;
    localparam logic [3:0] FN_ADD   = 4'h1;
    localparam logic [3:0] FN_SUB   = 4'h2;
    localparam logic [3:0] FN_INC   = 4'h3;
    localparam logic [3:0] FN_DEC   = 4'h4;
    localparam logic [3:0] FN_ADDI  = 4'h5;
    localparam logic [3:0] FN_SUBI  = 4'h6;
    localparam logic [3:0] FN_XOR   = 4'h7;
    localparam logic [3:0] FN_NOT   = 4'h8;
    localparam logic [3:0] FN_BEQ   = 4'h9;
    localparam logic [3:0] FN_BNE   = 4'hA;
    localparam logic [3:0] FN_BLT   = 4'hB;
    localparam logic [3:0] FN_BGT   = 4'hC;
    localparam logic [3:0] OP_RSVD  = 4'hD;
    localparam logic [3:0] FN_LOAD  = 4'hE;
    localparam logic [3:0] FN_STORE = 4'hF;

    typedef struct packed {
        logic [3:0] func;
        logic       use_imm;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       reads_rd;  // rd is a source operand, so it matters for load-use
        logic       live;      // occupies an execute slot (not NOP / reserved)
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode to control mapping. Reserved opcode decodes as a
// NOP with the illegal flag raised.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            FN_ADD, FN_SUB, FN_INC, FN_DEC, FN_XOR, FN_NOT: begin
                ctrl.func     = opcode;
                ctrl.reg_we   = 1'b1;
                ctrl.reads_rd = 1'b1;
                ctrl.live     = 1'b1;
            end
            FN_ADDI, FN_SUBI: begin
                ctrl.func     = opcode;
                ctrl.use_imm  = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.reads_rd = 1'b1;
                ctrl.live     = 1'b1;
            end
            FN_BEQ, FN_BNE, FN_BLT, FN_BGT: begin
                ctrl.func     = opcode;
                ctrl.reads_rd = 1'b1;
                ctrl.live     = 1'b1;
            end
            FN_LOAD: begin
                ctrl.func    = opcode;
                ctrl.use_imm = 1'b1;
                ctrl.mem_re  = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.live    = 1'b1;
            end
            FN_STORE: begin
                ctrl.func     = opcode;
                ctrl.use_imm  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.reads_rd = 1'b1;
                ctrl.live     = 1'b1;
            end
            OP_RSVD: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-and-issue stage for the 8-bit ALU: ID and EX pipeline registers,
// load-use bubble insertion, flag capture and branch resolution with flush.
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               ex_valid,
    output logic [3:0]         ex_func,
    output logic [1:0]         ex_rd,
    output logic [1:0]         ex_rs,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_use_imm,
    output logic               ex_reg_we,
    output logic               ex_mem_re,
    output logic               ex_mem_we,
    input  logic               alu_z,
    input  logic               alu_carry,
    output logic               flag_z,
    output logic               flag_c,
    output logic               br_taken,
    output logic [DATA_W-1:0]  br_offset,
    output logic               illegal
);

    ctrl_t             dec_ctrl;
    logic              dec_illegal;

    logic              id_valid;
    ctrl_t             id_ctrl;
    logic [1:0]        id_rd;
    logic [1:0]        id_rs;
    logic [DATA_W-1:0] id_imm;

    logic              ex_we_q;
    logic              ex_re_q;
    logic              ex_mwe_q;

    logic              hazard;
    logic              advance;
    logic              accept;
    logic              take;

    instr_decode u_decode (
        .opcode  (instr[OPC_HI:OPC_LO]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // EX always retires in one cycle, so the only thing holding ID is a load-use hit.
    assign hazard  = id_valid && ex_valid && ex_re_q &&
                     ((ex_rd == id_rs) || (id_ctrl.reads_rd && (ex_rd == id_rd)));
    assign advance = ~hazard;
    assign in_ready = ~id_valid | (advance & ~hazard);
    assign accept   = in_valid & in_ready;

    assign ex_reg_we = ex_valid & ex_we_q;
    assign ex_mem_re = ex_valid & ex_re_q;
    assign ex_mem_we = ex_valid & ex_mwe_q;

    always_comb begin
        take = 1'b0;
        if (ex_valid) begin
            case (ex_func)
                FN_BEQ:         take = alu_z;
                FN_BNE:         take = ~alu_z;
                FN_BLT, FN_BGT: take = alu_carry;
                default:        take = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid   <= 1'b0;
            id_ctrl    <= '0;
            id_rd      <= '0;
            id_rs      <= '0;
            id_imm     <= '0;
            ex_valid   <= 1'b0;
            ex_func    <= FN_NOP;
            ex_rd      <= '0;
            ex_rs      <= '0;
            ex_imm     <= '0;
            ex_use_imm <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_re_q    <= 1'b0;
            ex_mwe_q   <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            br_taken   <= 1'b0;
            br_offset  <= '0;
            illegal    <= 1'b0;
        end else begin
            br_taken <= take;
            if (take)
                br_offset <= ex_imm;

            if (ex_valid) begin
                flag_z <= alu_z;
                flag_c <= alu_carry;
            end

            if (take) begin
                // Taken branch kills ID, EX and whatever is being accepted now.
                id_valid <= 1'b0;
                ex_valid <= 1'b0;
                illegal  <= 1'b0;
            end else begin
                illegal <= accept & dec_illegal;

                if (advance) begin
                    ex_valid   <= id_valid & id_ctrl.live;
                    ex_func    <= id_ctrl.func;
                    ex_rd      <= id_rd;
                    ex_rs      <= id_rs;
                    ex_imm     <= id_imm;
                    ex_use_imm <= id_ctrl.use_imm;
                    ex_we_q    <= id_ctrl.reg_we;
                    ex_re_q    <= id_ctrl.mem_re;
                    ex_mwe_q   <= id_ctrl.mem_we;
                end else begin
                    ex_valid <= 1'b0;
                end

                if (accept) begin
                    id_valid <= 1'b1;
                    id_ctrl  <= dec_ctrl;
                    id_rd    <= instr[RD_HI:RD_LO];
                    id_rs    <= instr[RS_HI:RS_LO];
                    id_imm   <= instr[IMM_LO +: DATA_W];
                end else if (advance) begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule
